// File: rtl/vga_pkg.sv
// Shared definitions for the VGA raster timing generator: mode presets,
// pixel-scale encodings, generator states and the scale-to-shift helper.
package vga_pkg;

  // 1280x1024 @ 60 Hz, 108 MHz pixel clock, positive syncs
  localparam int VGA1280_H_ACT  = 1280;
  localparam int VGA1280_H_FP   = 48;
  localparam int VGA1280_H_SYNC = 112;
  localparam int VGA1280_H_BP   = 248;
  localparam int VGA1280_V_ACT  = 1024;
  localparam int VGA1280_V_FP   = 1;
  localparam int VGA1280_V_SYNC = 3;
  localparam int VGA1280_V_BP   = 38;
  localparam bit VGA1280_HS_POL = 1'b1;
  localparam bit VGA1280_VS_POL = 1'b1;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock, negative syncs
  localparam int VGA640_H_ACT  = 640;
  localparam int VGA640_H_FP   = 16;
  localparam int VGA640_H_SYNC = 96;
  localparam int VGA640_H_BP   = 48;
  localparam int VGA640_V_ACT  = 480;
  localparam int VGA640_V_FP   = 10;
  localparam int VGA640_V_SYNC = 2;
  localparam int VGA640_V_BP   = 33;
  localparam bit VGA640_HS_POL = 1'b0;
  localparam bit VGA640_VS_POL = 1'b0;

  // scale_sel encodings; the reserved code behaves like x1
  localparam logic [1:0] SCALE_X1   = 2'd0;
  localparam logic [1:0] SCALE_X2   = 2'd1;
  localparam logic [1:0] SCALE_X4   = 2'd2;
  localparam logic [1:0] SCALE_RSVD = 2'd3;

  // Generator is idle (held by enable=0 or just out of reset) or running
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } gen_state_e;

  // Right-shift applied to the raster counters for a given scale selection
  function automatic logic [1:0] scale_shift(input logic [1:0] sel);
    case (sel)
      SCALE_X2: return 2'd1;
      SCALE_X4: return 2'd2;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle from the raster generator to the PPU / display side.
interface vga_timing_gen_if #(
  parameter int CNT_W   = 12,
  parameter int FRAME_W = 16
);

  logic               hsync;
  logic               vsync;
  logic               blank_n;
  logic [CNT_W-1:0]   pixel_x;
  logic [CNT_W-1:0]   pixel_y;
  logic               frame_start;
  logic               update;
  logic [FRAME_W-1:0] frame_cnt;

  modport master (
    output hsync, vsync, blank_n, pixel_x, pixel_y, frame_start, update, frame_cnt
  );

  modport slave (
    input hsync, vsync, blank_n, pixel_x, pixel_y, frame_start, update, frame_cnt
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: counts 0..TOT-1 on each step, flags the wrap and the
// active / sync regions of the current count.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACT   = 1280,
  parameter int FP    = 48,
  parameter int SYNC  = 112,
  parameter int BP    = 248,
  parameter int CNT_W = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             step,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             in_act,
  output logic             in_sync
);

  localparam int TOT = ACT + FP + SYNC + BP;
  localparam logic [CNT_W-1:0] L_LAST    = CNT_W'(TOT - 1);
  localparam logic [CNT_W-1:0] L_ACT     = CNT_W'(ACT);
  localparam logic [CNT_W-1:0] L_SYNC_LO = CNT_W'(ACT + FP);
  localparam logic [CNT_W-1:0] L_SYNC_HI = CNT_W'(ACT + FP + SYNC);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  // Wrap is a stepping clock at the last count; it also drives the next axis
  always_comb begin
    w_wrap = step && (r_cnt == L_LAST);
  end

  // Count register: clear dominates, otherwise advance and wrap on step
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (step) begin
      r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign cnt     = r_cnt;
  assign wrap    = w_wrap;
  assign in_act  = (r_cnt < L_ACT);
  assign in_sync = (r_cnt >= L_SYNC_LO) && (r_cnt < L_SYNC_HI);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: syncs, blanking, scaled pixel
// coordinates, frame_start / update pulses and a completed-frame counter.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACT   = VGA1280_H_ACT,
  parameter int H_FP    = VGA1280_H_FP,
  parameter int H_SYNC  = VGA1280_H_SYNC,
  parameter int H_BP    = VGA1280_H_BP,
  parameter int V_ACT   = VGA1280_V_ACT,
  parameter int V_FP    = VGA1280_V_FP,
  parameter int V_SYNC  = VGA1280_V_SYNC,
  parameter int V_BP    = VGA1280_V_BP,
  parameter bit HS_POL  = VGA1280_HS_POL,
  parameter bit VS_POL  = VGA1280_VS_POL,
  parameter int CNT_W   = 12,
  parameter int FRAME_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       scale_sel,
  vga_timing_gen_if.master vid
);

  localparam logic [CNT_W-1:0] L_V_ACT = CNT_W'(V_ACT);

  logic [CNT_W-1:0]   w_h_cnt;
  logic               w_h_wrap;
  logic               w_h_act;
  logic               w_h_sync;
  logic [CNT_W-1:0]   w_v_cnt;
  logic               w_v_wrap;
  logic               w_v_act;
  logic               w_v_sync;

  gen_state_e         r_state;
  gen_state_e         w_state_next;
  logic               w_load_scale;
  logic [1:0]         r_shift;

  logic               w_blank_n;
  logic               w_frame_first;
  logic               w_vblank_entry;

  logic               r_hsync;
  logic               r_vsync;
  logic               r_blank_n;
  logic [CNT_W-1:0]   r_pixel_x;
  logic [CNT_W-1:0]   r_pixel_y;
  logic               r_frame_start;
  logic               r_update;
  logic [FRAME_W-1:0] r_frame_cnt;

  vga_axis_counter #(
    .ACT   (H_ACT),
    .FP    (H_FP),
    .SYNC  (H_SYNC),
    .BP    (H_BP),
    .CNT_W (CNT_W)
  ) u_h_axis (
    .clock   (clock),
    .reset   (reset),
    .clear   (!enable),
    .step    (enable),
    .cnt     (w_h_cnt),
    .wrap    (w_h_wrap),
    .in_act  (w_h_act),
    .in_sync (w_h_sync)
  );

  vga_axis_counter #(
    .ACT   (V_ACT),
    .FP    (V_FP),
    .SYNC  (V_SYNC),
    .BP    (V_BP),
    .CNT_W (CNT_W)
  ) u_v_axis (
    .clock   (clock),
    .reset   (reset),
    .clear   (!enable),
    .step    (w_h_wrap),
    .cnt     (w_v_cnt),
    .wrap    (w_v_wrap),
    .in_act  (w_v_act),
    .in_sync (w_v_sync)
  );

  // Generator state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Running follows enable directly; idle only remembers that a restart is pending
  always_comb begin
    w_state_next = enable ? ST_RUN : ST_IDLE;
  end

  // Scale loads on the first running clock and at every frame wrap, so frames never change scale midway
  always_comb begin
    w_load_scale = 1'b0;
    if (enable && ((r_state == ST_IDLE) || w_v_wrap)) begin
      w_load_scale = 1'b1;
    end
  end

  // Scale register, held while idle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_shift <= 2'd0;
    end else if (w_load_scale) begin
      r_shift <= scale_shift(scale_sel);
    end
  end

  // Decode of the current raster position
  always_comb begin
    w_blank_n      = w_h_act && w_v_act;
    w_frame_first  = (w_h_cnt == '0) && (w_v_cnt == '0);
    w_vblank_entry = (w_h_cnt == '0) && (w_v_cnt == L_V_ACT);
  end

  // Output registers: one clock behind the counters; enable=0 forces reset values except frame_cnt
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_hsync       <= !HS_POL;
      r_vsync       <= !VS_POL;
      r_blank_n     <= 1'b0;
      r_pixel_x     <= '0;
      r_pixel_y     <= '0;
      r_frame_start <= 1'b0;
      r_update      <= 1'b0;
      r_frame_cnt   <= '0;
    end else if (!enable) begin
      r_hsync       <= !HS_POL;
      r_vsync       <= !VS_POL;
      r_blank_n     <= 1'b0;
      r_pixel_x     <= '0;
      r_pixel_y     <= '0;
      r_frame_start <= 1'b0;
      r_update      <= 1'b0;
    end else begin
      r_hsync       <= w_h_sync ? HS_POL : !HS_POL;
      r_vsync       <= w_v_sync ? VS_POL : !VS_POL;
      r_blank_n     <= w_blank_n;
      r_pixel_x     <= w_blank_n ? (w_h_cnt >> r_shift) : '0;
      r_pixel_y     <= w_blank_n ? (w_v_cnt >> r_shift) : '0;
      r_frame_start <= w_frame_first;
      r_update      <= w_vblank_entry;
      if (w_frame_first) begin
        r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
      end
    end
  end

  assign vid.hsync       = r_hsync;
  assign vid.vsync       = r_vsync;
  assign vid.blank_n     = r_blank_n;
  assign vid.pixel_x     = r_pixel_x;
  assign vid.pixel_y     = r_pixel_y;
  assign vid.frame_start = r_frame_start;
  assign vid.update      = r_update;
  assign vid.frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a tiny 16x8 raster.
module tb_vga_timing_gen;

  localparam int H_ACT  = 8;
  localparam int H_FP   = 2;
  localparam int H_SYNC = 2;
  localparam int H_BP   = 4;
  localparam int V_ACT  = 4;
  localparam int V_FP   = 1;
  localparam int V_SYNC = 1;
  localparam int V_BP   = 2;
  localparam int H_TOT  = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int F_TOT  = H_TOT * V_TOT;

  logic       clock;
  logic       reset;
  logic       enable;
  logic [1:0] scale_sel;

  int checks;
  int errors;

  // Reference model state: raster position as a flat clock index within the frame
  int mPos;
  bit mIdle;
  int mFrameCnt;
  int mShift;

  int eHs, eVs, eBl, ePx, ePy, eFs, eUp, eFc;

  int capHs[F_TOT];
  int capVs[F_TOT];
  int capBl[F_TOT];
  int capUp[F_TOT];
  int capPx[F_TOT];
  int capPy[F_TOT];
  int capFs[F_TOT];
  int capFc[F_TOT];

  vga_timing_gen_if #(.CNT_W(12), .FRAME_W(16)) vid_if ();

  vga_timing_gen #(
    .H_ACT   (H_ACT),
    .H_FP    (H_FP),
    .H_SYNC  (H_SYNC),
    .H_BP    (H_BP),
    .V_ACT   (V_ACT),
    .V_FP    (V_FP),
    .V_SYNC  (V_SYNC),
    .V_BP    (V_BP),
    .HS_POL  (1'b1),
    .VS_POL  (1'b1),
    .CNT_W   (12),
    .FRAME_W (16)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .scale_sel (scale_sel),
    .vid       (vid_if.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int shiftOf(input logic [1:0] sel);
    if (sel == 2'd1) return 1;
    if (sel == 2'd2) return 2;
    return 0;
  endfunction

  // Reference model and per-cycle comparison of every output
  always @(posedge clock) begin
    int h;
    int v;
    if (!reset) begin
      mPos = 0; mIdle = 1'b1; mFrameCnt = 0; mShift = 0;
      eHs = 0; eVs = 0; eBl = 0; ePx = 0; ePy = 0; eFs = 0; eUp = 0; eFc = 0;
    end else if (!enable) begin
      mPos = 0; mIdle = 1'b1;
      eHs = 0; eVs = 0; eBl = 0; ePx = 0; ePy = 0; eFs = 0; eUp = 0; eFc = mFrameCnt;
    end else begin
      h   = mPos % H_TOT;
      v   = mPos / H_TOT;
      eHs = (h >= H_ACT + H_FP && h < H_ACT + H_FP + H_SYNC) ? 1 : 0;
      eVs = (v >= V_ACT + V_FP && v < V_ACT + V_FP + V_SYNC) ? 1 : 0;
      eBl = (h < H_ACT && v < V_ACT) ? 1 : 0;
      ePx = eBl ? (h >> mShift) : 0;
      ePy = eBl ? (v >> mShift) : 0;
      eFs = (mPos == 0) ? 1 : 0;
      eUp = (mPos == V_ACT * H_TOT) ? 1 : 0;
      if (mPos == 0) mFrameCnt = (mFrameCnt + 1) % 65536;
      eFc = mFrameCnt;
      if (mIdle || mPos == F_TOT - 1) mShift = shiftOf(scale_sel);
      mIdle = 1'b0;
      mPos  = (mPos + 1) % F_TOT;
    end
    #1;
    checkOutput("hsync",       vid_if.hsync,       eHs);
    checkOutput("vsync",       vid_if.vsync,       eVs);
    checkOutput("blank_n",     vid_if.blank_n,     eBl);
    checkOutput("pixel_x",     vid_if.pixel_x,     ePx);
    checkOutput("pixel_y",     vid_if.pixel_y,     ePy);
    checkOutput("frame_start", vid_if.frame_start, eFs);
    checkOutput("update",      vid_if.update,      eUp);
    checkOutput("frame_cnt",   vid_if.frame_cnt,   eFc);
  end

  task automatic waitFrameStart();
    bit found;
    found = 1'b0;
    for (int n = 0; n < 3 * F_TOT && !found; n++) begin
      @(negedge clock);
      if (vid_if.frame_start) found = 1'b1;
    end
    if (!found) checkOutput("frame_start_timeout", 0, 1);
  endtask

  // Record one frame of outputs starting at frame_start; optionally change scale_sel mid-frame
  task automatic applyStimulus(input int changeAt, input logic [1:0] newSel);
    waitFrameStart();
    for (int i = 0; i < F_TOT; i++) begin
      if (i > 0) @(negedge clock);
      capHs[i] = vid_if.hsync;
      capVs[i] = vid_if.vsync;
      capBl[i] = vid_if.blank_n;
      capUp[i] = vid_if.update;
      capPx[i] = vid_if.pixel_x;
      capPy[i] = vid_if.pixel_y;
      capFs[i] = vid_if.frame_start;
      capFc[i] = vid_if.frame_cnt;
      if (i == changeAt) scale_sel = newSel;
    end
  endtask

  task automatic checkFrameShape(input int expFc);
    int nHs, nVs, nBl, nUp, upAt, firstHs;
    nHs = 0; nVs = 0; nBl = 0; nUp = 0; upAt = -1; firstHs = -1;
    for (int i = 0; i < F_TOT; i++) begin
      nHs += capHs[i];
      nVs += capVs[i];
      nBl += capBl[i];
      nUp += capUp[i];
      if (capUp[i] == 1) upAt = i;
      if (capHs[i] == 1 && firstHs < 0) firstHs = i;
    end
    checkOutput("hsync_clocks_per_frame", nHs, 16);
    checkOutput("hsync_first_clock", firstHs, 10);
    checkOutput("vsync_clocks_per_frame", nVs, 16);
    checkOutput("blank_n_clocks_per_frame", nBl, 32);
    checkOutput("update_count", nUp, 1);
    checkOutput("update_offset", upAt, 64);
    checkOutput("frame_cnt_value", capFc[0], expFc);
  endtask

  initial begin
    int expX2[8];
    int expY2[4];
    int prevFc;
    expX2 = '{0, 0, 1, 1, 2, 2, 3, 3};
    expY2 = '{0, 0, 1, 1};
    checks = 0;
    errors = 0;
    reset = 1'b0;
    enable = 1'b1;
    scale_sel = 2'd0;

    // 1: reset held, then released
    repeat (3) @(negedge clock);
    checkOutput("reset_hsync", vid_if.hsync, 0);
    checkOutput("reset_blank_n", vid_if.blank_n, 0);
    checkOutput("reset_frame_cnt", vid_if.frame_cnt, 0);
    reset = 1'b1;
    @(posedge clock);
    #2;
    checkOutput("first_frame_start", vid_if.frame_start, 1);
    checkOutput("first_blank_n", vid_if.blank_n, 1);
    checkOutput("first_pixel_x", vid_if.pixel_x, 0);
    checkOutput("first_pixel_y", vid_if.pixel_y, 0);
    checkOutput("first_frame_cnt", vid_if.frame_cnt, 1);

    // 2 and 4: three free-running frames
    for (int f = 1; f <= 3; f++) begin
      applyStimulus(-1, 2'd0);
      checkFrameShape(f);
    end

    // 3: scale change mid-frame takes effect on the next frame
    applyStimulus(20, 2'd1);
    for (int k = 0; k < 8; k++) checkOutput("x1_pixel_x", capPx[2 * H_TOT + k], k);
    applyStimulus(-1, 2'd1);
    for (int k = 0; k < 8; k++) checkOutput("x2_pixel_x", capPx[k], expX2[k]);
    for (int r = 0; r < 4; r++) checkOutput("x2_pixel_y", capPy[r * H_TOT], expY2[r]);
    checkOutput("x2_frame_cnt", capFc[0], 5);

    // 5: enable drop at h_cnt=5 of line 2
    waitFrameStart();
    repeat (2 * H_TOT + 4) @(negedge clock);
    prevFc = vid_if.frame_cnt;
    enable = 1'b0;
    @(negedge clock);
    checkOutput("idle_blank_n", vid_if.blank_n, 0);
    checkOutput("idle_pixel_x", vid_if.pixel_x, 0);
    checkOutput("idle_frame_cnt_hold", vid_if.frame_cnt, prevFc);
    repeat (9) @(negedge clock);
    enable = 1'b1;
    @(negedge clock);
    checkOutput("reenable_frame_start", vid_if.frame_start, 1);
    checkOutput("reenable_frame_cnt", vid_if.frame_cnt, prevFc + 1);

    // 6: asynchronous reset between edges
    repeat (23) @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_hsync", vid_if.hsync, 0);
    checkOutput("async_vsync", vid_if.vsync, 0);
    checkOutput("async_blank_n", vid_if.blank_n, 0);
    checkOutput("async_pixel_x", vid_if.pixel_x, 0);
    checkOutput("async_frame_start", vid_if.frame_start, 0);
    checkOutput("async_update", vid_if.update, 0);
    checkOutput("async_frame_cnt", vid_if.frame_cnt, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    // Randomized scale changes and enable drops against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      if ($urandom_range(0, 39) == 0) scale_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 249) == 0) begin
        enable = 1'b0;
        repeat ($urandom_range(1, 20)) @(negedge clock);
        enable = 1'b1;
      end
    end

    @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
